regfile_scoreboard: RTL and testbench

- Parametrised successor to the 32x32 MIPS register file: 2 async read ports, 1 sync write port, configurable data width, depth, optional hardwired zero register, optional write-to-read bypass.
- Adds a per-register busy scoreboard for multicycle producers (loads, mult/div). The decode stage reserves a destination, and the writeback clears it.
- Sits between decode/hazard unit and writeback of the pipelined core.

---
 rtl/regfile_scoreboard.sv | 104 ++++++++++
 tb/tb_regfile_scoreboard.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two async read ports, one sync write port
// and a per-register busy scoreboard for multicycle producers.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveRegister,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Busy1,
  output logic              Busy2,
  output logic [ADDR_W:0]   BusyCount
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  logic wr_ok;
  logic rsv_ok;

  assign wr_ok  = RegWrite &&
                  !((ZERO_REG != 0) && (WriteRegister == '0));
  assign rsv_ok = Reserve &&
                  !((ZERO_REG != 0) && (ReserveRegister == '0));

  // Reserve is applied after the clear so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[WriteRegister] = 1'b0;
    if (rsv_ok)
      busy_nxt[ReserveRegister] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= '0;
      BusyCount <= '0;
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      busy      <= busy_nxt;
      BusyCount <= cnt_nxt;
      if (wr_ok)
        regs[WriteRegister] <= WriteData;
    end
  end

  logic zero1;
  logic zero2;
  logic hit1;
  logic hit2;

  assign zero1 = (ZERO_REG != 0) && (ReadRegister1 == '0);
  assign zero2 = (ZERO_REG != 0) && (ReadRegister2 == '0);
  assign hit1  = (BYPASS != 0) && wr_ok &&
                 (ReadRegister1 == WriteRegister);
  assign hit2  = (BYPASS != 0) && wr_ok &&
                 (ReadRegister2 == WriteRegister);

  always_comb begin
    ReadData1 = regs[ReadRegister1];
    Busy1     = busy[ReadRegister1];
    if (zero1) begin
      ReadData1 = '0;
      Busy1     = 1'b0;
    end else if (hit1) begin
      ReadData1 = WriteData;
      Busy1     = rsv_ok &&
                  (ReserveRegister == ReadRegister1);
    end
  end

  always_comb begin
    ReadData2 = regs[ReadRegister2];
    Busy2     = busy[ReadRegister2];
    if (zero2) begin
      ReadData2 = '0;
      Busy2     = 1'b0;
    end else if (hit2) begin
      ReadData2 = WriteData;
      Busy2     = rsv_ok &&
                  (ReserveRegister == ReadRegister2);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default build plus a
// 16-bit, 8-entry, no-bypass build.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic        we_a, rsv_a;
  logic [4:0]  wa_a, rr_a, ra1_a, ra2_a;
  logic [31:0] wd_a, rd1_a, rd2_a;
  logic        b1_a, b2_a;
  logic [5:0]  cnt_a;

  logic        we_b, rsv_b;
  logic [2:0]  wa_b, rr_b, ra1_b, ra2_b;
  logic [15:0] wd_b, rd1_b, rd2_b;
  logic        b1_b, b2_b;
  logic [3:0]  cnt_b;

  regfile_scoreboard u_a (
    .clk(clk), .reset(reset),
    .RegWrite(we_a), .WriteRegister(wa_a), .WriteData(wd_a),
    .Reserve(rsv_a), .ReserveRegister(rr_a),
    .ReadRegister1(ra1_a), .ReadRegister2(ra2_a),
    .ReadData1(rd1_a), .ReadData2(rd2_a),
    .Busy1(b1_a), .Busy2(b2_a), .BusyCount(cnt_a)
  );

  regfile_scoreboard #(
    .DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)
  ) u_b (
    .clk(clk), .reset(reset),
    .RegWrite(we_b), .WriteRegister(wa_b), .WriteData(wd_b),
    .Reserve(rsv_b), .ReserveRegister(rr_b),
    .ReadRegister1(ra1_b), .ReadRegister2(ra2_b),
    .ReadData1(rd1_b), .ReadData2(rd2_b),
    .Busy1(b1_b), .Busy2(b2_b), .BusyCount(cnt_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    we_a = 0; rsv_a = 0; wa_a = 0; rr_a = 0;
    ra1_a = 0; ra2_a = 0; wd_a = 0;
    we_b = 0; rsv_b = 0; wa_b = 0; rr_b = 0;
    ra1_b = 0; ra2_b = 0; wd_b = 0;
    tick;
    reset = 1'b0;
    ra1_a = 5; ra2_a = 9;
    #1;
    chk("rst_rd1", rd1_a, 32'h0);
    chk("rst_rd2", rd2_a, 32'h0);
    chk("rst_b1", b1_a, 0);
    chk("rst_cnt", cnt_a, 0);

    we_a = 1; wa_a = 5; wd_a = 32'hDEADBEEF;
    tick;
    we_a = 0; ra1_a = 5; ra2_a = 5;
    #1;
    chk("r5_rd1", rd1_a, 32'hDEADBEEF);
    chk("r5_rd2", rd2_a, 32'hDEADBEEF);
    chk("r5_b1", b1_a, 0);
    chk("r5_b2", b2_a, 0);

    we_a = 1; wa_a = 0; wd_a = 32'h12345678; ra1_a = 0;
    #1;
    chk("r0_byp", rd1_a, 32'h0);
    tick;
    we_a = 0;
    #1;
    chk("r0_rd", rd1_a, 32'h0);
    rsv_a = 1; rr_a = 0;
    tick;
    rsv_a = 0;
    #1;
    chk("r0_cnt", cnt_a, 0);
    chk("r0_busy", b1_a, 0);

    rsv_a = 1; rr_a = 8;
    tick;
    rsv_a = 0; ra1_a = 8;
    #1;
    chk("r8_busy", b1_a, 1);
    chk("r8_cnt", cnt_a, 1);
    we_a = 1; wa_a = 8; wd_a = 32'hA5A5A5A5;
    #1;
    chk("r8_byp_rd", rd1_a, 32'hA5A5A5A5);
    chk("r8_byp_b", b1_a, 0);
    tick;
    we_a = 0;
    #1;
    chk("r8_cnt0", cnt_a, 0);
    chk("r8_rd", rd1_a, 32'hA5A5A5A5);

    we_a = 1; wa_a = 3; wd_a = 32'd7;
    rsv_a = 1; rr_a = 3; ra2_a = 3;
    #1;
    chk("r3_byp_rd", rd2_a, 32'd7);
    chk("r3_byp_b", b2_a, 1);
    tick;
    we_a = 0; rsv_a = 0; ra1_a = 3;
    #1;
    chk("r3_rd", rd1_a, 32'd7);
    chk("r3_busy", b1_a, 1);
    chk("r3_cnt", cnt_a, 1);

    we_a = 1; wa_a = 10; wd_a = 32'h55;
    rsv_a = 1; rr_a = 11;
    tick;
    we_a = 0; rsv_a = 0; ra1_a = 10; ra2_a = 11;
    #1;
    chk("r10_rd", rd1_a, 32'h55);
    chk("r10_b", b1_a, 0);
    chk("r11_b", b2_a, 1);
    chk("r11_cnt", cnt_a, 2);

    for (int i = 1; i < 32; i++) begin
      rsv_a = 1; rr_a = 5'(i);
      tick;
    end
    rsv_a = 0;
    #1;
    chk("all_cnt", cnt_a, 31);
    reset = 1; we_a = 1; wa_a = 2; wd_a = 32'hFF;
    tick;
    reset = 0; we_a = 0; ra1_a = 2; ra2_a = 31;
    #1;
    chk("rst2_cnt", cnt_a, 0);
    chk("rst2_rd", rd1_a, 32'h0);
    chk("rst2_b", b1_a, 0);
    chk("rst2_r31", rd2_a, 32'h0);
    chk("rst2_r31b", b2_a, 0);

    we_b = 1; wa_b = 7; wd_b = 16'hBEEF; ra2_b = 7;
    #1;
    chk("b_old", rd2_b, 32'h0);
    tick;
    we_b = 0;
    #1;
    chk("b_new", rd2_b, 32'hBEEF);
    rsv_b = 1; rr_b = 7;
    tick;
    rsv_b = 0;
    we_b = 1; wa_b = 7; wd_b = 16'h1234;
    #1;
    chk("b_busy_pre", b2_b, 1);
    chk("b_cnt1", cnt_b, 1);
    tick;
    we_b = 0;
    #1;
    chk("b_busy_post", b2_b, 0);
    chk("b_rd_post", rd2_b, 32'h1234);
    for (int i = 0; i < 8; i++) begin
      rsv_b = 1; rr_b = 3'(i);
      tick;
    end
    rsv_b = 0;
    #1;
    chk("b_cnt_all", cnt_b, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
